// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: controller states and
// default geometry.
package regfile_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 32;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port. The returned word and busy flag are the values the
// addressed register holds after this edge's write and scoreboard updates.
module regfile_rdport #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [AW-1:0]   raddr_i,
  input  logic [XLEN-1:0] mem_word_i,
  input  logic            mem_busy_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            sb_set_i,
  input  logic [AW-1:0]   sb_addr_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            rbusy_o
);

  logic [XLEN-1:0] rdata_d, rdata_q;
  logic            rbusy_d, rbusy_q;
  logic            zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (raddr_i == '0);

  // we_i and sb_set_i arrive already qualified; a new producer overrides a
  // same-cycle write's busy clear.
  always_comb begin
    rdata_d = mem_word_i;
    rbusy_d = mem_busy_i;
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_d = wdata_i;
      rbusy_d = 1'b0;
    end
    if (sb_set_i && (sb_addr_i == raddr_i)) begin
      rbusy_d = 1'b1;
    end
    if (!en_i || zero_hit) begin
      rdata_d = '0;
      rbusy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rbusy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata_o = rdata_q;
  assign rbusy_o = rbusy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard. After reset the
// controller sweeps every entry to zero before accepting traffic.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic            busy_q [DEPTH];
  logic            busy_d [DEPTH];
  logic            we_eff, sb_eff;

  assign ready  = (state_q == READY);
  assign we_eff = ready && we && !((ZERO_REG != 0) && (waddr == '0));
  assign sb_eff = ready && sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    case (state_q)
      SWEEP: begin
        mem_d[cnt_q]  = '0;
        busy_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (we_eff) begin
          mem_d[waddr]  = wdata;
          busy_d[waddr] = 1'b0;
        end
        if (sb_eff) begin
          busy_d[sb_addr] = 1'b1;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage has no reset value; the sweep zeroes it. Reset only freezes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[k*AW +: AW];

    regfile_rdport #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .clk        (clk),
      .rst        (rst),
      .en_i       (ready),
      .raddr_i    (ra),
      .mem_word_i (mem_q[ra]),
      .mem_busy_i (busy_q[ra]),
      .we_i       (we_eff),
      .waddr_i    (waddr),
      .wdata_i    (wdata),
      .sb_set_i   (sb_eff),
      .sb_addr_i  (sb_addr),
      .rdata_o    (rdata[k*XLEN +: XLEN]),
      .rbusy_o    (rbusy[k])
    );
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Clocking SHALL use one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Parameter XLEN, 32, data width in bits.
REQ-003 Parameter DEPTH, 32, number of registers (power of two, >=2); AW = log2(DEPTH).
REQ-004 Parameter NREAD, 2, number of independent read ports (1..4).
REQ-005 Parameter ZERO_REG, 1, when 1 register 0 SHALL read as zero and ignore writes and busy marks.
REQ-006 Port clk  input  1  rising-edge clock.
REQ-007 Port rst  input  1  synchronous active-high reset; starts the clear sweep.
REQ-008 Port ready  output  1  high once the clear sweep is complete.
REQ-009 Port we  input  1  write enable.
REQ-010 Port waddr  input  AW  write address.
REQ-011 Port wdata  input  XLEN  write data.
REQ-012 Port raddr  input  NREAD*AW  flattened read addresses; port k uses bits [k*AW +: AW].
REQ-013 Port rdata  output  NREAD*XLEN  flattened registered read data.
REQ-014 Port rbusy  output  NREAD  registered busy flag of each addressed register.
REQ-015 Port sb_set  input  1  marks register sb_addr busy (pending producer).
REQ-016 Port sb_addr  input  AW  scoreboard set address.

Function
REQ-017 FSM states SHALL be SWEEP and READY; rst forces SWEEP with sweep counter 0.
REQ-018 In SWEEP each cycle SHALL write 0 to mem[cnt] and clear busy[cnt], then increment cnt; at cnt==DEPTH-1 the next state SHALL be READY.
REQ-019 ready SHALL equal (state==READY), so it rises DEPTH edges after the first edge with rst low.
REQ-020 While not ready, we and sb_set SHALL be ignored and all rdata/rbusy SHALL be 0.
REQ-021 In READY, we at edge t SHALL store wdata into mem[waddr] and clear busy[waddr].
REQ-022 Read latency SHALL be 1 cycle: raddr sampled at edge t drives rdata/rbusy after edge t.
REQ-023 Bypass: a read sampled in the same cycle as a write to the same non-ignored address SHALL return wdata, not the old value.
REQ-024 rbusy bypass: same-cycle write to the read address SHALL yield 0 unless sb_set targets that address in the same cycle, in which case 1.
REQ-025 Simultaneous sb_set and we to the same address: busy SHALL end set (new producer wins).
REQ-026 With ZERO_REG=1, address 0 SHALL always give rdata 0 and rbusy 0, whether bypassed or not.
REQ-027 All read ports SHALL operate independently; identical addresses on several ports SHALL be legal.
REQ-028 Reset asserted mid-READY SHALL abort all activity and restart the sweep; ready SHALL drop on the next edge.

Reset
REQ-029 On rst: state=SWEEP, cnt=0, ready=0, rdata=0, rbusy=0; memory contents are cleared by the sweep, not by reset itself.
REQ-030 A write presented in the same cycle as rst SHALL be discarded.

Structure
REQ-031 Package regfile_pkg SHALL hold the state enumeration and the default XLEN/DEPTH constants.
REQ-032 Sub-module regfile_rdport SHALL implement one registered read port with bypass and zero-register masking, instantiated NREAD times.

Verification
REQ-033 Reset with DEPTH=32, then hold rst low -> ready=0 for 32 edges, 1 afterwards; every register reads 0.
REQ-034 Write 0xDEADBEEF to reg 5, then read port 0 addr 5 on the next cycle -> rdata0=0xDEADBEEF one cycle later.
REQ-035 Write 0x12345678 to reg 7 while port 1 reads addr 7 in the same cycle -> rdata1=0x12345678 (bypass).
REQ-036 Write 0xFFFFFFFF to reg 0 and sb_set reg 0, then read addr 0 on both ports -> rdata=0, rbusy=0.
REQ-037 sb_set reg 3, read -> rbusy=1; write reg 3 -> rbusy=0; sb_set and write reg 3 in the same cycle -> rbusy=1.
REQ-038 Assert rst for 1 cycle mid-traffic after reg 9 = 0xA5A5A5A5 -> ready=0, then after 32 edges ready=1 and reg 9 reads 0.
